// File: rtl/mul_share_if.sv
// Request/response bundle between the clients and the multiplier-sharing arbiter.
// Clients (master) drive requests and accept responses.
// The arbiter (slave) grants requests and returns tagged products.
interface mul_share_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*WIDTH-1:0]    rsp_p;
    logic [IDW-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_id
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one external combinational multiplier among NREQ clients.
// One transaction is in flight at a time: IDLE (grant) -> MUL (capture product)
// -> RESP (hold result until consumed) -> IDLE.
module mul_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_share_if.slave         bus,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    input  logic [2*WIDTH-1:0] mult_p,
    output logic               busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDW-1:0]     rr_ptr_r;
    logic [IDW-1:0]     id_q_r;
    logic [IDW-1:0]     rsp_id_r;
    logic [IDW-1:0]     grant_s;
    logic               any_s;
    logic [IDW:0]       pick_s;
    logic [NREQ-1:0]    req_ready_s;
    logic [WIDTH-1:0]   mult_a_r;
    logic [WIDTH-1:0]   mult_b_r;
    logic [2*WIDTH-1:0] rsp_p_r;
    logic               rsp_valid_r;
    logic [WIDTH-1:0]   a_arr_s [NREQ];
    logic [WIDTH-1:0]   b_arr_s [NREQ];

    // First valid requester after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0]   res;
        logic [IDW-1:0] idx_v;
        res = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v = IDW'((int'(ptr) + k) % NREQ);
            if (!res[IDW] && valid[idx_v]) begin
                res = {1'b1, idx_v};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Unpack the flat operand buses into per-requester lanes.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr_s[i] = bus.req_a[i*WIDTH +: WIDTH];
        assign b_arr_s[i] = bus.req_b[i*WIDTH +: WIDTH];
    end

    assign pick_s  = rr_pick(bus.req_valid, rr_ptr_r);
    assign any_s   = pick_s[IDW];
    assign grant_s = pick_s[IDW-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and the combinational accept strobe.
    always_comb begin
        state_nxt_s = state_r;
        req_ready_s = '0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_nxt_s          = MUL;
                    req_ready_s[grant_s] = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (rsp_valid_r && bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand capture, product capture, response hold and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_a_r    <= '0;
            mult_b_r    <= '0;
            id_q_r      <= '0;
            rsp_p_r     <= '0;
            rsp_id_r    <= '0;
            rsp_valid_r <= 1'b0;
            rr_ptr_r    <= IDW'(NREQ - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        mult_a_r <= a_arr_s[grant_s];
                        mult_b_r <= b_arr_s[grant_s];
                        id_q_r   <= grant_s;
                    end
                end
                MUL: begin
                    rsp_p_r     <= mult_p;
                    rsp_id_r    <= id_q_r;
                    rsp_valid_r <= 1'b1;
                end
                RESP: begin
                    if (rsp_valid_r && bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rr_ptr_r    <= rsp_id_r;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_p     = rsp_p_r;
    assign bus.rsp_id    = rsp_id_r;
    assign mult_a        = mult_a_r;
    assign mult_b        = mult_b_r;
    assign busy          = (state_r != IDLE);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with a behavioural multiplier.
module tb_mul_share_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] mult_a;
    logic [3:0] mult_b;
    logic [7:0] mult_p;
    logic       busy;
    int         checks;
    int         errors;

    mul_share_if #(.NREQ(4), .WIDTH(4), .IDW(2)) bus ();

    mul_share_arbiter #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .mult_a (mult_a),
        .mult_b (mult_b),
        .mult_p (mult_p),
        .busy   (busy)
    );

    // Combinational multiplier stand-in.
    assign mult_p = {4'b0000, mult_a} * {4'b0000, mult_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b0000; bus.req_a = 16'h0000; bus.req_b = 16'h0000; bus.rsp_ready = 1'b1;
        #12;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0h exp 0", bus.rsp_valid); end
        checks++; if (bus.rsp_p !== 8'h00) begin errors++; $display("FAIL reset_rsp_p got %0h exp 0", bus.rsp_p); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0h exp 0", bus.rsp_id); end
        checks++; if ({mult_a, mult_b} !== 8'h00) begin errors++; $display("FAIL reset_mult_ops got %0h exp 0", {mult_a, mult_b}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %0h exp 0", bus.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (busy !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_req got busy=%0h ready=%0h exp 0 0", busy, bus.req_ready); end
        end
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0001; bus.req_a = 16'h0003; bus.req_b = 16'h0005;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %0h exp 1", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_mul got %0h exp 0", bus.req_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0h exp 1", busy); end
        checks++; if (mult_a !== 4'd3 || mult_b !== 4'd5) begin errors++; $display("FAIL single_ops got %0d %0d exp 3 5", mult_a, mult_b); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp got %0h exp 0", bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %0h exp 1", bus.rsp_valid); end
        checks++; if (bus.rsp_p !== 8'd15) begin errors++; $display("FAIL single_rsp_p got %0d exp 15", bus.rsp_p); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id got %0d exp 0", bus.rsp_id); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got valid=%0h busy=%0h exp 0 0", bus.rsp_valid, busy); end
        checks++; if (mult_a !== 4'd3 || mult_b !== 4'd5) begin errors++; $display("FAIL single_ops_hold got %0d %0d exp 3 5", mult_a, mult_b); end
    endtask

    task automatic test_max_values();
        bus.req_valid = 4'b0100; bus.req_a = 16'h0F00; bus.req_b = 16'h0F00;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL max_grant got %0h exp 4", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++; if (bus.rsp_p !== 8'hE1 || bus.rsp_id !== 2'd2) begin errors++; $display("FAIL max_product got p=%0h id=%0d exp e1 2", bus.rsp_p, bus.rsp_id); end
        tick();
        bus.req_valid = 4'b0010; bus.req_a = 16'h0000; bus.req_b = 16'h0090;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL zero_grant got %0h exp 2", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 8'h00 || bus.rsp_id !== 2'd1) begin errors++; $display("FAIL zero_product got v=%0h p=%0h id=%0d exp 1 0 1", bus.rsp_valid, bus.rsp_p, bus.rsp_id); end
        tick();
    endtask

    task automatic test_fairness();
        logic [7:0] exp_p [4];
        int         order [5];
        exp_p = '{8'd2, 8'd6, 8'd12, 8'd20};
        order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.req_valid = 4'b1111; bus.req_a = 16'h4321; bus.req_b = 16'h5432; bus.rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            checks++; if (bus.req_ready !== (4'b0001 << order[n])) begin errors++; $display("FAIL fair_grant%0d got %0h exp %0h", n, bus.req_ready, 4'b0001 << order[n]); end
            tick();
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL fair_ready_mul%0d got %0h exp 0", n, bus.req_ready); end
            tick();
            checks++; if (bus.rsp_id !== 2'(order[n]) || bus.rsp_p !== exp_p[order[n]]) begin errors++; $display("FAIL fair_rsp%0d got id=%0d p=%0d exp %0d %0d", n, bus.rsp_id, bus.rsp_p, order[n], exp_p[order[n]]); end
            checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL fair_ready_resp%0d got %0h exp 0", n, bus.req_ready); end
            tick();
        end
        bus.req_valid = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        // Last grant was requester 0: requester 3 alone, then requester 1 queued.
        bus.req_valid = 4'b1000; bus.req_a = 16'h7020; bus.req_b = 16'h6030; bus.rsp_ready = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant got %0h exp 8", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0010;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 8'd42 || bus.rsp_id !== 2'd3) begin errors++; $display("FAIL bp_hold%0d got v=%0h p=%0d id=%0d exp 1 42 3", i, bus.rsp_valid, bus.rsp_p, bus.rsp_id); end
            checks++; if (bus.req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL bp_ready%0d got ready=%0h busy=%0h exp 0 1", i, bus.req_ready, busy); end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got v=%0h busy=%0h exp 0 0", bus.rsp_valid, busy); end
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_next_grant got %0h exp 2", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_p !== 8'd6) begin errors++; $display("FAIL bp_second got id=%0d p=%0d exp 1 6", bus.rsp_id, bus.rsp_p); end
        tick();
    endtask

    task automatic test_abort();
        // Last grant was requester 1, so requester 3 wins over nothing else here.
        bus.req_valid = 4'b1000; bus.req_a = 16'h5000; bus.req_b = 16'h5000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL abort_grant got %0h exp 8", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_mul got busy=%0h exp 1", busy); end
        rst_n = 1'b0;
        #2;
        checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || mult_a !== 4'd0) begin errors++; $display("FAIL abort_reset got busy=%0h v=%0h a=%0d exp 0 0 0", busy, bus.rsp_valid, mult_a); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_rsp%0d got v=%0h busy=%0h exp 0 0", i, bus.rsp_valid, busy); end
        end
        bus.req_valid = 4'b1111; bus.req_a = 16'h1119; bus.req_b = 16'h1117;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL abort_next_grant got %0h exp 1", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        tick();
        checks++; if (bus.rsp_id !== 2'd0 || bus.rsp_p !== 8'd63) begin errors++; $display("FAIL abort_after got id=%0d p=%0d exp 0 63", bus.rsp_id, bus.rsp_p); end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_max_values();
        test_fairness();
        test_backpressure();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
